// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer carrying PC, instruction
// and branch-prediction sideband, with valid/ready on both sides and a full flush on redirect.
module fetch_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  in_pc_i,
    input  logic [XLEN-1:0]  in_inst_i,
    input  logic             in_bp_taken_i,
    input  logic [XLEN-1:0]  in_bp_target_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [XLEN-1:0]  out_inst_o,
    output logic             out_bp_taken_o,
    output logic [XLEN-1:0]  out_bp_target_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            bp_taken;
        logic [XLEN-1:0] bp_target;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q;
    logic   [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic               empty, full, push, pop;
    entry_t             head, in_ent;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty = (rd_q == wr_q);
    assign full  = (rd_q[AW-1:0] == wr_q[AW-1:0]) && (rd_q[AW] != wr_q[AW]);

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    assign push        = in_valid_i && !full;
    assign pop         = out_ready_i && !empty;

    assign in_ent = '{pc: in_pc_i, inst: in_inst_i, bp_taken: in_bp_taken_i,
                      bp_target: in_bp_target_i};

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        if (flush_i) begin
            rd_d = wr_q;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            mem_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            if (push && !flush_i) mem_q[wr_q[AW-1:0]] <= in_ent;
        end
    end

    // Head is read straight from storage; pointer distance mod 2*DEPTH is the occupancy.
    assign head            = mem_q[rd_q[AW-1:0]];
    assign out_pc_o        = head.pc;
    assign out_inst_o      = head.inst;
    assign out_bp_taken_o  = head.bp_taken;
    assign out_bp_target_o = head.bp_target;
    assign count_o         = CNT_W'(wr_q - rd_q);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_fetch_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0]  in_pc, in_inst, in_bp_target;
    logic             in_bp_taken;
    logic [XLEN-1:0]  out_pc, out_inst, out_bp_target;
    logic             out_bp_taken;
    logic [CNT_W-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_pc_i(in_pc), .in_inst_i(in_inst),
        .in_bp_taken_i(in_bp_taken), .in_bp_target_i(in_bp_target),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_inst_o(out_inst),
        .out_bp_taken_o(out_bp_taken), .out_bp_target_o(out_bp_target),
        .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            tk;
        logic [XLEN-1:0] tgt;
    } ent_t;

    ent_t q[$];
    bit   armed   = 0;
    bit   zero_ok = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of accepted entries, updated from the inputs seen at each edge.
    always @(posedge clk) begin
        bit   do_push, do_pop;
        ent_t e;
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = out_ready && (q.size() > 0);
        e = '{pc: in_pc, inst: in_inst, tk: in_bp_taken, tgt: in_bp_target};
        if (rst) begin
            q.delete();
            armed   = 1;
            zero_ok = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                zero_ok = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            if (q.size() > 0) begin
                chk("out_pc", 64'(out_pc), 64'(q[0].pc));
                chk("out_inst", 64'(out_inst), 64'(q[0].inst));
                chk("out_bp_taken", 64'(out_bp_taken), 64'(q[0].tk));
                chk("out_bp_target", 64'(out_bp_target), 64'(q[0].tgt));
            end else if (zero_ok) begin
                chk("reset_data", {out_pc, out_inst}, 64'd0);
                chk("reset_bp", {out_bp_target, 31'd0, out_bp_taken}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic tk,
                         input logic [XLEN-1:0] tgt);
        in_valid     = v;
        in_pc        = pc;
        in_inst      = pc ^ 32'hA5A5_0000;
        in_bp_taken  = tk;
        in_bp_target = tgt;
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 0;
        drive(0, 0, 0, 0);

        // Reset then idle
        tick(); tick();
        rst = 0;
        tick();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_pc", 64'(out_pc), 64'd0);

        // Fill to full with decode stalled
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h100 + 32'(4 * k), k == 2, (k == 2) ? 32'h200 : 32'h0);
            tick();
        end
        drive(1, 32'h110, 0, 0);
        tick(); tick();
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_pc), 64'h100);

        // Drain in order
        drive(0, 32'h110, 0, 0);
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * k)));
            if (k == 2) begin
                chk("drain_bp_taken", 64'(out_bp_taken), 64'd1);
                chk("drain_bp_target", 64'(out_bp_target), 64'h200);
            end
            tick();
        end
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("drained_count", 64'(count), 64'd0);

        // Simultaneous push/pop at count=2 across wrap
        out_ready = 0;
        drive(1, 32'h110, 0, 0); tick();
        drive(1, 32'h114, 0, 0); tick();
        out_ready = 1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            drive(1, 32'h120 + 32'(4 * k), k[0], 32'h1000 + 32'(k));
            tick();
            if (k == 0) chk("pp_first_head", 64'(out_pc), 64'h114);
            chk("pp_count", 64'(count), 64'd2);
        end
        chk("pp_last_head", 64'(out_pc), 64'h148);

        // Flush mid-stream with push and pop pending
        out_ready = 0;
        drive(1, 32'h150, 0, 0); tick();
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1; out_ready = 1;
        drive(1, 32'h300, 0, 0); tick();
        flush = 0; out_ready = 0;
        drive(0, 0, 0, 0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        drive(1, 32'h400, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_head", 64'(out_pc), 64'h400);

        // Reset overriding flush mid-operation
        drive(1, 32'h404, 0, 0); tick();
        drive(1, 32'h408, 0, 0); tick();
        chk("pre_rst_count", 64'(count), 64'd3);
        rst = 1; flush = 1; out_ready = 1;
        drive(1, 32'h40C, 1, 32'h40C); tick();
        rst = 0; flush = 0; out_ready = 0;
        drive(0, 0, 0, 0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        drive(1, 32'h500, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_head", 64'(out_pc), 64'h500);

        // Randomized traffic; fetch keeps its entry stable while stalled
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 99) < 60);
            if (!(in_valid && !in_ready))
                drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 1), $urandom);
            tick();
        end
        rst = 0; flush = 0;
        drive(0, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
